// File: rtl/cpu_defs.sv
// Shared definitions for the multi-cycle MIPS32 core: reset vector,
// instruction-fetch state encoding and fetch fault codes.
package cpu_defs;

   localparam logic [31:0] PC_RESET_VECTOR = 32'h0000_3000;

   localparam logic [1:0] IF_IDLE  = 2'd0;
   localparam logic [1:0] IF_REQ   = 2'd1;
   localparam logic [1:0] IF_LATCH = 2'd2;
   localparam logic [1:0] IF_FAULT = 2'd3;

   localparam logic [1:0] FC_NONE     = 2'b00;
   localparam logic [1:0] FC_MISALIGN = 2'b01;
   localparam logic [1:0] FC_TIMEOUT  = 2'b10;

endpackage

// File: rtl/ifetch_timer.sv
// Loadable 8-bit up-counter that measures the imem_ack wait.
// The terminal-count flag is high while the count equals TERMINAL.
module ifetch_timer #(
   parameter int unsigned TERMINAL = 15
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [7:0] load_value,
   input  logic       en,
   output logic       tc
);

   logic [7:0] count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= 8'd0;
      end else if (load) begin
         count <= load_value;
      end else if (en) begin
         count <= count + 8'd1;
      end
   end

   assign tc = (count == 8'(TERMINAL));

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: reads imem at pc over req/ack, latches IR,
// pulses pc_wr with the sequential or redirect next-PC, flags fetch faults.
module ifetch_ctrl
   import cpu_defs::*;
#(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned PC_STEP = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc,
   input  logic        fetch_start,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   output logic [31:0] ir,
   output logic        ir_valid,
   output logic        pc_wr,
   output logic [31:0] npc,
   output logic        busy,
   output logic        fault,
   output logic [1:0]  fault_code
);

   // imem handshake: imem_req rises on REQ entry with imem_addr, both held
   // until the first cycle imem_ack is sampled high in REQ; ack is ignored
   // in every other state.

   logic [1:0] state;
   logic [1:0] next_state;
   logic       pc_aligned;
   logic       timer_load;
   logic       timer_en;
   logic       timer_tc;

   assign pc_aligned = (pc[1:0] == 2'b00);

   ifetch_timer #(
      .TERMINAL (TIMEOUT - 1)
   ) u_timer (
      .clk        (clk),
      .reset      (reset),
      .load       (timer_load),
      .load_value (8'd0),
      .en         (timer_en),
      .tc         (timer_tc)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IF_IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IF_IDLE: begin
            if (!br_taken && fetch_start) begin
               next_state = pc_aligned ? IF_REQ : IF_FAULT;
            end
         end
         IF_REQ: begin
            if (imem_ack) begin
               next_state = IF_LATCH;
            end else if (timer_tc) begin
               next_state = IF_FAULT;
            end
         end
         IF_LATCH: next_state = IF_IDLE;
         default:  next_state = IF_FAULT;
      endcase
   end

   always_comb begin
      busy       = (state != IF_IDLE);
      fault      = (state == IF_FAULT);
      timer_load = (state == IF_IDLE);
      timer_en   = (state == IF_REQ) && !imem_ack;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         imem_req   <= 1'b0;
         imem_addr  <= 32'd0;
         ir         <= 32'd0;
         ir_valid   <= 1'b0;
         pc_wr      <= 1'b0;
         npc        <= 32'd0;
         fault_code <= FC_NONE;
      end else begin
         pc_wr <= 1'b0;
         case (state)
            IF_IDLE: begin
               if (br_taken) begin
                  // A back-to-back redirect is dropped so pc_wr never stays high
                  pc_wr    <= ~pc_wr;
                  ir_valid <= 1'b0;
                  if (!pc_wr) begin
                     npc <= br_target;
                  end
               end else if (fetch_start) begin
                  ir_valid <= 1'b0;
                  if (pc_aligned) begin
                     imem_req  <= 1'b1;
                     imem_addr <= pc;
                  end else begin
                     fault_code <= FC_MISALIGN;
                  end
               end
            end
            IF_REQ: begin
               if (imem_ack) begin
                  ir       <= imem_rdata;
                  imem_req <= 1'b0;
                  pc_wr    <= 1'b1;
                  npc      <= imem_addr + 32'(PC_STEP);
                  ir_valid <= 1'b1;
               end else if (timer_tc) begin
                  imem_req   <= 1'b0;
                  fault_code <= FC_TIMEOUT;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
